seg_scan_driver: RTL

- Consumes the 56-bit, 8-digit, active-low 7-segment frame produced by the display output mux.
- Time-multiplexes the frame onto one shared 7-bit segment bus plus 8 active-low digit enables for the physical display.
- Adds an anti-ghosting blank guard at every digit switch, tear-free frame snapshots, and per-digit blinking used to flag the field being edited in set modes.

---
 rtl/seg_scan_driver_if.sv | 25 ++
 rtl/seg_scan_driver.sv | 108 ++++++++++
 2 files changed

// File: rtl/seg_scan_driver_if.sv
// Frame-in / scan-out bundle for the 8-digit 7-segment scan driver.
// The master supplies the frame and blink mask; the slave drives the display.
interface seg_scan_driver_if;
  logic [55:0] seg_in;
  logic [7:0]  blink_mask;
  logic [6:0]  seg_out;
  logic [7:0]  an_out;
  logic        frame_done;

  modport master (
    output seg_in,
    output blink_mask,
    input  seg_out,
    input  an_out,
    input  frame_done
  );

  modport slave (
    input  seg_in,
    input  blink_mask,
    output seg_out,
    output an_out,
    output frame_done
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit 7-segment driver with a blank guard at each
// digit switch, per-frame snapshots and per-digit blinking.
module seg_scan_driver #(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  seg_scan_driver_if.slave bus
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CW-1:0] CNT_MAX   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_FRAMES - 1);

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      digit_q, digit_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            phase_q, phase_d;
  logic            load_pending_q;
  logic [7:0][6:0] shadow_q, shadow_d;
  logic [7:0]      mask_q, mask_d;

  logic            slot_end;
  logic            wrap;
  logic            blank;
  logic [6:0]      seg_d;
  logic [7:0]      an_d;

  // Outputs are derived from next-state values so the registered
  // drive lines up with the slot position the counter lands on.
  always_comb begin
    slot_end    = 1'b0;
    wrap        = 1'b0;
    cnt_d       = cnt_q;
    digit_d     = digit_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    shadow_d    = shadow_q;
    mask_d      = mask_q;
    blank       = 1'b1;
    seg_d       = 7'h7F;
    an_d        = 8'hFF;

    slot_end = (cnt_q == CNT_MAX);
    wrap     = slot_end && (digit_q == 3'd7);

    if (slot_end) begin
      cnt_d   = '0;
      digit_d = digit_q + 3'd1;
    end else begin
      cnt_d   = cnt_q + CW'(1);
    end

    if (wrap) begin
      if (blink_cnt_q == BLINK_MAX) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end

    if (load_pending_q || wrap) begin
      shadow_d = bus.seg_in;
      mask_d   = bus.blink_mask;
    end

    blank = (cnt_d < BLANK_END);
    if (!blank) begin
      an_d = ~(8'd1 << digit_d);
      if (!(phase_d && mask_d[digit_d])) begin
        seg_d = shadow_d[digit_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      digit_q        <= '0;
      blink_cnt_q    <= '0;
      phase_q        <= 1'b0;
      load_pending_q <= 1'b1;
      shadow_q       <= {8{7'h7F}};
      mask_q         <= '0;
      bus.seg_out    <= 7'h7F;
      bus.an_out     <= 8'hFF;
      bus.frame_done <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      digit_q        <= digit_d;
      blink_cnt_q    <= blink_cnt_d;
      phase_q        <= phase_d;
      load_pending_q <= 1'b0;
      shadow_q       <= shadow_d;
      mask_q         <= mask_d;
      bus.seg_out    <= seg_d;
      bus.an_out     <= an_d;
      bus.frame_done <= wrap;
    end
  end

endmodule
